// File: rtl/div_hilo_ctrl.sv
// HI/LO owner and sequencer around a 32-cycle unsigned iterative divider.
// Applies sign correction so DIV is signed; services MTHI/MTLO.
module div_hilo_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WRITE} state_t;

    localparam logic [2:0] OP_DIVU = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_MTHI = 3'b010;
    localparam logic [2:0] OP_MTLO = 3'b011;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        qNeg_q, qNeg_d;
    logic        rNeg_q, rNeg_d;
    logic        busySeen_q, busySeen_d;
    logic        start_q, start_d;
    logic        dbz_q, dbz_d;

    logic        isDiv;
    logic        isSigned;
    logic        rtZero;
    logic [31:0] rsMag;
    logic [31:0] rtMag;

    assign isDiv    = op_valid && ((op == OP_DIVU) || (op == OP_DIV));
    assign isSigned = (op == OP_DIV);
    assign rtZero   = (rt_val == 32'd0);
    assign rsMag    = (isSigned && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign rtMag    = (isSigned && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

    // Next-state, stall and register updates; WRITE deliberately ignores op_valid
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        qNeg_d     = qNeg_q;
        rNeg_d     = rNeg_q;
        busySeen_d = busySeen_q;
        start_d    = 1'b0;
        dbz_d      = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (isDiv) begin
                    if (rtZero) begin
                        dbz_d = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        dividend_d = rsMag;
                        divisor_d  = rtMag;
                        qNeg_d     = isSigned && (rs_val[31] ^ rt_val[31]);
                        rNeg_d     = isSigned && rs_val[31];
                        busySeen_d = 1'b0;
                        start_d    = 1'b1;
                        state_d    = LAUNCH;
                    end
                end else if (op_valid && (op == OP_MTHI)) begin
                    hi_d = rs_val;
                end else if (op_valid && (op == OP_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            LAUNCH: begin
                stall   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (div_busy) begin
                    busySeen_d = 1'b1;
                end
                if (busySeen_q && !div_busy) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                lo_d    = qNeg_q ? (32'd0 - div_q) : div_q;
                hi_d    = rNeg_q ? (32'd0 - div_r) : div_r;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            qNeg_q     <= 1'b0;
            rNeg_q     <= 1'b0;
            busySeen_q <= 1'b0;
            start_q    <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qNeg_q     <= qNeg_d;
            rNeg_q     <= rNeg_d;
            busySeen_q <= busySeen_d;
            start_q    <= start_d;
            dbz_q      <= dbz_d;
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_by_zero  = dbz_q;
    assign div_start    = start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl with a behavioural 32-cycle divider
// and an arithmetic reference model for HI/LO.
module tb_div_hilo_ctrl;

    logic        clock;
    logic        reset;
    logic        opValid;
    logic [2:0]  op;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;
    logic        divStart;
    logic [31:0] divDividend;
    logic [31:0] divDivisor;
    logic        divBusy;
    logic [31:0] divQ;
    logic [31:0] divR;

    div_hilo_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (opValid),
        .op          (op),
        .rs_val      (rsVal),
        .rt_val      (rtVal),
        .stall       (stall),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (divByZero),
        .div_start   (divStart),
        .div_dividend(divDividend),
        .div_divisor (divDivisor),
        .div_busy    (divBusy),
        .div_q       (divQ),
        .div_r       (divR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          isDbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelHi  = 32'd0;
    logic [31:0] modelLo  = 32'd0;

    // Behavioural divider: busy for 32 cycles starting the cycle after start
    int cntM;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            divBusy <= 1'b0;
            cntM    <= 0;
            divQ    <= 32'd0;
            divR    <= 32'd0;
        end else if (divStart && !divBusy) begin
            divBusy <= 1'b1;
            cntM    <= 32;
            divQ    <= (divDivisor == 0) ? 32'hFFFFFFFF : divDividend / divDivisor;
            divR    <= (divDivisor == 0) ? divDividend : divDividend % divDivisor;
        end else if (divBusy) begin
            cntM <= cntM - 1;
            if (cntM == 1) divBusy <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rHi, output logic [31:0] rLo);
        longint sa, sb, qq, rr;
        if (!sgn) begin
            rLo = a / b;
            rHi = a % b;
        end else begin
            sa  = {{32{a[31]}}, a};
            sb  = {{32{b[31]}}, b};
            qq  = sa / sb;
            rr  = sa % sb;
            rLo = qq[31:0];
            rHi = rr[31:0];
        end
    endtask

    // Issue one instruction, hold it while stalled, model its effect
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] eh, el;
        bit          done;
        if (o == 3'b000 || o == 3'b001) begin
            if (b == 32'd0) begin
                e.isDbz = 1'b1; e.hi = modelHi; e.lo = modelLo;
            end else begin
                refDiv(o == 3'b001, a, b, eh, el);
                modelHi = eh; modelLo = el;
                e.isDbz = 1'b0; e.hi = eh; e.lo = el;
            end
            expQ.push_back(e);
        end else if (o == 3'b010) begin
            modelHi = a;
        end else if (o == 3'b011) begin
            modelLo = a;
        end
        opValid = 1'b1; op = o; rsVal = a; rtVal = b;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL stall_timeout actual=stuck required=release");
        end
        @(posedge clock); #1;
        opValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        opValid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: pops an expectation when a divide retires or a div_by_zero pulse appears
    int runLen = 0, lastLen = 0, starts = 0;
    bit pending = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                runLen = 0; pending = 0; starts = 0;
            end else begin
                if (pending) begin
                    pending = 0;
                    if (expQ.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL unexpected_result actual=retire required=none");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("kind_div", 32'(e.isDbz), 32'd0);
                        checkOutput("div_hi", hi, e.hi);
                        checkOutput("div_lo", lo, e.lo);
                        checkOutput("stall_len", 32'(lastLen), 32'd35);
                        checkOutput("start_pulses", 32'(starts), 32'd1);
                    end
                    starts = 0;
                end
                if (divStart) starts++;
                if (stall) runLen++;
                else if (runLen > 0) begin
                    lastLen = runLen; runLen = 0; pending = 1;
                end
                if (divByZero) begin
                    if (expQ.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL unexpected_dbz actual=1 required=0");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("kind_dbz", 32'(e.isDbz), 32'd1);
                        checkOutput("dbz_hi", hi, e.hi);
                        checkOutput("dbz_lo", lo, e.lo);
                        checkOutput("dbz_starts", 32'(starts), 32'd0);
                    end
                    starts = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int sel;
        logic [31:0] a, b;
        reset = 1'b1; opValid = 1'b0; op = 3'b000; rsVal = 32'd0; rtVal = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_start", 32'(divStart), 32'd0);
        checkOutput("rst_dbz", 32'(divByZero), 32'd0);
        checkOutput("rst_dividend", divDividend, 32'd0);
        checkOutput("rst_divisor", divDivisor, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;

        applyStimulus(3'b000, 32'd100, 32'd7);
        applyStimulus(3'b001, 32'hFFFFFFF9, 32'd2);
        applyStimulus(3'b001, 32'd7, 32'hFFFFFFFE);
        applyStimulus(3'b001, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(3'b010, 32'h12345678, 32'd0);
        applyStimulus(3'b011, 32'h9ABCDEF0, 32'd0);
        applyStimulus(3'b000, 32'd5, 32'd0);
        idleCycles(2);
        applyStimulus(3'b000, 32'd9, 32'd4);
        applyStimulus(3'b000, 32'hFFFFFFFF, 32'h00010000);
        idleCycles(2);

        // Reset during WAIT, then confirm no stale write lands
        opValid = 1'b1; op = 3'b000; rsVal = 32'd1000; rtVal = 32'd3;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1; opValid = 1'b0;
        modelHi = 32'd0; modelLo = 32'd0;
        expQ.delete();
        @(negedge clock);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idleCycles(40);
        checkOutput("post_rst_hi", hi, 32'd0);
        checkOutput("post_rst_lo", lo, 32'd0);
        applyStimulus(3'b000, 32'd10, 32'd3);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            case (sel)
                0, 1:    applyStimulus(3'b000, a, b);
                2, 3:    applyStimulus(3'b001, a, b);
                4:       applyStimulus(3'($urandom_range(0, 1)), a, 32'd0);
                5:       applyStimulus(3'b010, a, b);
                6:       applyStimulus(3'b011, a, b);
                7:       applyStimulus(3'($urandom_range(4, 7)), a, b);
                8:       idleCycles($urandom_range(1, 4));
                default: applyStimulus(3'b001, {1'b1, a[30:0]}, {$urandom_range(0, 1) == 1, b[30:0] | 31'd1});
            endcase
        end

        idleCycles(50);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Sequencing controller between the CPU's decode/execute stage and the 32-cycle iterative unsigned divider. It launches divisions for DIV and DIVU, applying sign pre- and post-correction around the unsigned core so DIV is signed. It stalls the pipeline for the duration, owns the HI/LO architectural registers, and services MTHI/MTLO writes.

## Interface
- No parameters; all datapaths 32-bit.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  execute-stage instruction valid this cycle.
- op  in  3  000 DIVU, 001 DIV, 010 MTHI, 011 MTLO; others no-op.
- rs_val  in  32  dividend, or the MTHI/MTLO source.
- rt_val  in  32  divisor.
- stall  out  1  holds the pipeline; combinational.
- hi  out  32  HI register (remainder); registered.
- lo  out  32  LO register (quotient); registered.
- div_by_zero  out  1  one-cycle pulse on a divide with rt_val==0; registered.
- div_start  out  1  divider start; registered.
- div_dividend  out  32  operand to divider; registered.
- div_divisor  out  32  operand to divider; registered.
- div_busy  in  1  divider busy. Rises the cycle after start is sampled, stays high 32 cycles.
- div_q  in  32  divider quotient, valid while div_busy is low after completion.
- div_r  in  32  divider remainder, valid while div_busy is low after completion.

## Operation
- States: IDLE, LAUNCH, WAIT, WRITE. Reset state is IDLE.
- A divide op is op_valid with op 000 or 001.
- **IDLE, divide op, rt_val != 0**
  - Latch operand magnitudes. DIV: |rs_val| and |rt_val| (two's-complement negate if bit 31 set). DIVU: raw values.
  - Latch q_neg = DIV & (rs[31]^rt[31]) and r_neg = DIV & rs[31].
  - Clear busy_seen. Go to LAUNCH.
- **IDLE, divide op, rt_val == 0**
  - No launch, no stall.
  - Pulse div_by_zero the next cycle. HI/LO unchanged.
- **IDLE, MTHI / MTLO**
  - hi (or lo) <= rs_val at the clock edge. No stall.
- **LAUNCH**
  - div_start=1 for exactly this cycle, with operands stable. Go to WAIT.
- **WAIT**
  - Set busy_seen when div_busy=1.
  - When busy_seen & !div_busy, go to WRITE.
- **WRITE**
  - lo <= q_neg ? -div_q : div_q.
  - hi <= r_neg ? -div_r : div_r.
  - Go to IDLE.
  - op_valid/op are ignored in this state: it is the same instruction, now retiring.
- **stall** = (IDLE & divide op & rt_val!=0) | LAUNCH | WAIT. Low in WRITE.
- **Arithmetic**
  - Negation is 32-bit two's complement; results wrap.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- **Reset mid-operation** (any state)
  - Back to IDLE; hi=lo=0; div_start=0; div_by_zero=0.
  - The divider shares reset, so no stale completion is consumed.

## Timing
- **Reset values:** hi=0, lo=0, div_start=0, div_by_zero=0, div_dividend=0, div_divisor=0.
- stall is 0 after reset, given op_valid=0.
- **Divide with issue in cycle T0:**
  - T0: IDLE, stall=1.
  - T1: LAUNCH, div_start=1.
  - T2–T33: div_busy=1.
  - T34: WAIT sees busy low.
  - T35: WRITE, stall=0.
- New hi/lo are visible from T36.
- Stall lasts 35 cycles (T0–T34); the instruction advances at the end of T35.
- A divide presented at T36, in IDLE, launches normally with no idle gap required.
- MTHI/MTLO: single cycle, result visible the next cycle.
- div_by_zero: high for the one cycle after the offending issue cycle.

## Test plan
- Reset, then DIVU rs=100 rt=7 -> stall high exactly 35 cycles, div_start pulses once in T1, lo=14 and hi=2 at T36.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 7 / -2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, normal 35-cycle stall.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIVU 5 / 0 -> stall never asserts, div_by_zero one-cycle pulse, hi/lo unchanged.
- Back-to-back DIVU 9/4 then DIVU 0xFFFFFFFF/0x10000 -> op held during WRITE is not relaunched; second result lo=0xFFFF, hi=0xFFFF.
- Assert reset during WAIT (T20) -> next cycle state IDLE, stall=0, hi=lo=0, no later HI/LO write. A following DIVU 10/3 gives lo=3, hi=1.
